// File: rtl/spi_txn_logger.sv
// spi_txn_logger: passive host-SPI monitor that logs one record per transaction into a FIFO
module spi_txn_logger #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 14,
  localparam int RECORD_W = 34 + LEN_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                h_clk,
  input  logic                h_cs_n,
  input  logic                h_mosi,
  input  logic                flash_select,
  input  logic                enable,
  input  logic                clear,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [RECORD_W-1:0] rd_data,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, SKIP, COMMIT} state_t;

  state_t state, state_nx;
  logic [3:0] sync1, sync2;
  logic clk_d, cs_d, armed;
  logic [1:0] warm;
  logic s_clk, s_cs, s_mosi, s_sel;
  logic sclk_rise, cs_rise, cs_fall, byte_done, addr_done, addr_op;
  logic [4:0] bits;
  logic [7:0] op, op_nx;
  logic [23:0] addr;
  logic [LEN_W-1:0] len;
  logic has_addr, sel;
  logic [RECORD_W-1:0] rec;
  logic [RECORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop, full, wr_en;

  assign {s_sel, s_mosi, s_cs, s_clk} = sync2;
  assign sclk_rise = s_clk & ~clk_d;
  assign cs_rise = s_cs & ~cs_d;
  assign cs_fall = armed & cs_d & ~s_cs;
  assign op_nx = {op[6:0], s_mosi};
  assign addr_op = op_nx inside {8'h03, 8'h0B, 8'h02, 8'h20, 8'hD8};
  assign byte_done = sclk_rise && bits[2:0] == 3'd7;
  assign addr_done = sclk_rise && bits == 5'd23;

  // Two-flop synchronisers, edge-detect stage, and arming so a CS already low at reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      clk_d <= 1'b1;
      cs_d <= 1'b1;
      warm <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= {flash_select, h_mosi, h_cs_n, h_clk};
      sync2 <= sync1;
      clk_d <= s_clk;
      cs_d <= s_cs;
      warm <= warm + 2'(warm != 2'd3);
      armed <= armed | (warm == 2'd3 && s_cs);
    end
  end

  // Transaction state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end

  // Next-state decode: CS rise ends any active phase through a one-cycle COMMIT
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall) state_nx = enable ? OPCODE : SKIP;
      OPCODE:  state_nx = cs_rise ? COMMIT : byte_done ? (addr_op ? ADDR : DATA) : OPCODE;
      ADDR:    state_nx = cs_rise ? COMMIT : addr_done ? DATA : ADDR;
      DATA:    state_nx = cs_rise ? COMMIT : DATA;
      SKIP:    state_nx = cs_rise ? IDLE : SKIP;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Field capture: opcode and address shift in MSB first, len counts whole bytes and saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
      op <= '0;
      addr <= '0;
      len <= '0;
      has_addr <= 1'b0;
      sel <= 1'b0;
    end else if (state == IDLE) begin
      bits <= '0;
      op <= '0;
      addr <= '0;
      len <= '0;
      has_addr <= 1'b0;
    end else if (cs_rise) begin
      sel <= s_sel;
    end else if (sclk_rise) begin
      case (state)
        OPCODE: begin
          op <= op_nx;
          bits <= byte_done ? '0 : bits + 5'd1;
          if (byte_done) len <= LEN_W'(1);
        end
        ADDR: begin
          addr <= {addr[22:0], s_mosi};
          bits <= addr_done ? '0 : bits + 5'd1;
          if (addr_done) begin
            has_addr <= 1'b1;
            len <= LEN_W'(4);
          end
        end
        DATA: begin
          bits <= bits + 5'd1;
          if (byte_done && len != '1) len <= len + 1'b1;
        end
        default: bits <= bits;
      endcase
    end
  end

  assign rec = {sel, has_addr, op, has_addr ? addr : 24'd0, len};
  assign push = state == COMMIT && len != '0;
  assign pop = rd_valid && rd_ready;
  assign full = count == CNT_W'(DEPTH);
  assign wr_en = push && (!full || pop);

  // Record FIFO with drop accounting; clear overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= rec;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
      if (push && !wr_en) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + 8'(drop_cnt != 8'hFF);
      end
    end
  end

  assign rd_valid = count != '0;
  assign rd_data = mem[rd_ptr];
  assign fifo_count = count;
endmodule

// File: tb/tb_spi_txn_logger.sv
// tb_spi_txn_logger: directed vector table plus hand-written corner sequences for spi_txn_logger
module tb_spi_txn_logger;
  localparam int DEPTH = 8;
  localparam int LEN_W = 8;
  localparam int RW = 34 + LEN_W;

  logic clk = 0, rst_n = 0, h_clk = 0, h_cs_n = 1, h_mosi = 0, flash_select = 0;
  logic enable = 1, clear = 0, rd_ready = 0;
  logic rd_valid, overflow;
  logic [RW-1:0] rd_data;
  logic [3:0] fifo_count;
  logic [7:0] drop_cnt;
  int compared = 0, mismatched = 0;

  typedef struct {
    logic s;
    logic [7:0] op;
    int opb;
    logic [23:0] a;
    int ab;
    int nd;
    int tb;
    int n;
    logic [RW-1:0] r;
  } vec_t;

  vec_t v [9];

  spi_txn_logger #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
    .flash_select(flash_select), .enable(enable), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic s, input logic ha, input logic [7:0] op,
                                        input logic [23:0] a, input logic [LEN_W-1:0] l);
    return {s, ha, op, a, l};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      h_mosi = val[i];
      tick(3);
      h_clk = 1;
      tick(3);
      h_clk = 0;
    end
  endtask

  task automatic cs_low();
    h_cs_n = 0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(3);
    h_cs_n = 1;
    tick(8);
  endtask

  task automatic txn(input logic s, input logic [7:0] op, input int opb, input logic [23:0] a,
                     input int ab, input int nd, input int tb);
    flash_select = s;
    cs_low();
    bits(32'(op), opb);
    if (ab > 0) bits(32'(a >> (24 - ab)), ab);
    for (int i = 0; i < nd; i++) bits(32'(8'h5A ^ i[7:0]), 8);
    if (tb > 0) bits(32'h5, tb);
    cs_high();
  endtask

  task automatic pop(input string name, input logic [RW-1:0] exp);
    check({name, " valid"}, 64'(rd_valid), 64'd1);
    check(name, 64'(rd_data), 64'(exp));
    rd_ready = 1;
    tick(1);
    rd_ready = 0;
  endtask

  initial begin
    v[0] = '{1'b1, 8'h03, 8, 24'h123456, 24, 4, 0, 1, rec(1'b1, 1'b1, 8'h03, 24'h123456, 8'd8)};
    v[1] = '{1'b0, 8'h06, 8, 24'h0, 0, 0, 0, 1, rec(1'b0, 1'b0, 8'h06, 24'h0, 8'd1)};
    v[2] = '{1'b0, 8'h06, 5, 24'h0, 0, 0, 0, 0, '0};
    v[3] = '{1'b0, 8'h9F, 8, 24'h0, 0, 3, 0, 1, rec(1'b0, 1'b0, 8'h9F, 24'h0, 8'd4)};
    v[4] = '{1'b1, 8'h0B, 8, 24'hABCDEF, 24, 1, 0, 1, rec(1'b1, 1'b1, 8'h0B, 24'hABCDEF, 8'd5)};
    v[5] = '{1'b0, 8'h02, 8, 24'h123456, 16, 0, 0, 1, rec(1'b0, 1'b0, 8'h02, 24'h0, 8'd1)};
    v[6] = '{1'b1, 8'h20, 8, 24'h000FF0, 24, 0, 0, 1, rec(1'b1, 1'b1, 8'h20, 24'h000FF0, 8'd4)};
    v[7] = '{1'b0, 8'hD8, 8, 24'h800001, 24, 2, 3, 1, rec(1'b0, 1'b1, 8'hD8, 24'h800001, 8'd6)};
    v[8] = '{1'b1, 8'h9F, 8, 24'h0, 0, 0, 7, 1, rec(1'b1, 1'b0, 8'h9F, 24'h0, 8'd1)};

    tick(3);
    rst_n = 1;
    tick(6);
    check("reset rd_valid", 64'(rd_valid), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'd0);
    check("reset fifo_count", 64'(fifo_count), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);

    for (int i = 0; i < 9; i++) begin
      txn(v[i].s, v[i].op, v[i].opb, v[i].a, v[i].ab, v[i].nd, v[i].tb);
      check($sformatf("vec%0d count", i), 64'(fifo_count), 64'(v[i].n));
      if (v[i].n == 1) pop($sformatf("vec%0d record", i), v[i].r);
      check($sformatf("vec%0d drained", i), 64'(fifo_count), 64'd0);
    end

    flash_select = 0;
    cs_low();
    bits(32'h06, 8);
    tick(3);
    h_cs_n = 1;
    repeat (3) @(posedge clk);
    #1 check("latency edge3 rd_valid", 64'(rd_valid), 64'd0);
    @(posedge clk);
    #1 check("latency edge4 rd_valid", 64'(rd_valid), 64'd1);
    tick(4);
    pop("latency record", rec(1'b0, 1'b0, 8'h06, 24'h0, 8'd1));

    rd_ready = 1;
    tick(2);
    rd_ready = 0;
    check("pop empty count", 64'(fifo_count), 64'd0);
    check("pop empty valid", 64'(rd_valid), 64'd0);

    for (int i = 0; i < DEPTH + 2; i++) txn(1'b0, 8'(8'h10 + i), 8, 24'h0, 0, 0, 0);
    check("full count", 64'(fifo_count), 64'(DEPTH));
    check("full overflow", 64'(overflow), 64'd1);
    check("full drop_cnt", 64'(drop_cnt), 64'd2);
    check("full head", 64'(rd_data), 64'(rec(1'b0, 1'b0, 8'h10, 24'h0, 8'd1)));

    flash_select = 0;
    cs_low();
    bits(32'h42, 8);
    tick(3);
    h_cs_n = 1;
    tick(3);
    rd_ready = 1;
    tick(1);
    rd_ready = 0;
    tick(2);
    check("push+pop count", 64'(fifo_count), 64'(DEPTH));
    check("push+pop drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 1; i < DEPTH; i++) pop($sformatf("order%0d", i), rec(1'b0, 1'b0, 8'(8'h10 + i), 24'h0, 8'd1));
    pop("order last", rec(1'b0, 1'b0, 8'h42, 24'h0, 8'd1));
    check("drained count", 64'(fifo_count), 64'd0);

    cs_low();
    bits(32'h43, 8);
    tick(3);
    h_cs_n = 1;
    tick(3);
    clear = 1;
    tick(1);
    clear = 0;
    tick(2);
    check("clear count", 64'(fifo_count), 64'd0);
    check("clear drop_cnt", 64'(drop_cnt), 64'd0);
    check("clear overflow", 64'(overflow), 64'd0);
    check("clear valid", 64'(rd_valid), 64'd0);

    enable = 0;
    txn(1'b0, 8'h03, 8, 24'h123456, 24, 1, 0);
    enable = 1;
    check("disabled count", 64'(fifo_count), 64'd0);

    flash_select = 1;
    cs_low();
    bits(32'h9F, 8);
    enable = 0;
    bits(32'h77, 8);
    cs_high();
    enable = 1;
    check("mid disable count", 64'(fifo_count), 64'd1);
    pop("mid disable record", rec(1'b1, 1'b0, 8'h9F, 24'h0, 8'd2));

    flash_select = 0;
    cs_low();
    bits(32'h03, 8);
    bits(32'h123, 12);
    rst_n = 0;
    tick(2);
    rst_n = 1;
    bits(32'h456, 12);
    bits(32'hAA, 8);
    cs_high();
    check("post-reset no record", 64'(fifo_count), 64'd0);
    txn(1'b0, 8'h06, 8, 24'h0, 0, 0, 0);
    check("post-reset count", 64'(fifo_count), 64'd1);
    pop("post-reset record", rec(1'b0, 1'b0, 8'h06, 24'h0, 8'd1));

    txn(1'b1, 8'h0B, 8, 24'h0, 24, (1 << LEN_W) + 10, 0);
    check("sat count", 64'(fifo_count), 64'd1);
    pop("sat record", rec(1'b1, 1'b1, 8'h0B, 24'h0, 8'hFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
